// File: rtl/rv32_pkg.sv
// Shared RV32 decode definitions: opcodes, ALU codes and decode-word (DCR) bit positions.
package rv32_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [2:0] ALU_ADD  = 3'd0;
   localparam logic [2:0] ALU_SUB  = 3'd1;
   localparam logic [2:0] ALU_SLT  = 3'd2;
   localparam logic [2:0] ALU_SLTU = 3'd3;
   localparam logic [2:0] ALU_XOR  = 3'd4;
   localparam logic [2:0] ALU_OR   = 3'd5;
   localparam logic [2:0] ALU_AND  = 3'd6;

   // DCR = {auipc, funct3, R, I_CS, I_L, I_J, S, U, B, J, MUL, I, SFT, ALUop[2:0], SFTop[1:0]}
   localparam int unsigned DCR_W         = 20;
   localparam int unsigned DCR_SFTOP_LSB = 0;
   localparam int unsigned DCR_ALUOP_LSB = 2;
   localparam int unsigned DCR_SFT       = 5;
   localparam int unsigned DCR_I         = 6;
   localparam int unsigned DCR_MUL       = 7;
   localparam int unsigned DCR_J         = 8;
   localparam int unsigned DCR_B         = 9;
   localparam int unsigned DCR_U         = 10;
   localparam int unsigned DCR_S         = 11;
   localparam int unsigned DCR_I_J       = 12;
   localparam int unsigned DCR_I_L       = 13;
   localparam int unsigned DCR_I_CS      = 14;
   localparam int unsigned DCR_R         = 15;
   localparam int unsigned DCR_F3_LSB    = 16;
   localparam int unsigned DCR_AUIPC     = 19;

   // ALU operation for OP/OP-IMM funct3; sub only honoured for funct3=000
   function automatic logic [2:0] alu_op(input logic [2:0] f3, input logic sub);
      logic [2:0] op;
      case (f3)
         3'b000:  op = sub ? ALU_SUB : ALU_ADD;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b110:  op = ALU_OR;
         3'b111:  op = ALU_AND;
         default: op = ALU_ADD;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/rv32_decode_fwd_if.sv
// Fetch-side, regfile, forwarding and EX-side signals of the decode stage.
interface rv32_decode_fwd_if
   import rv32_pkg::*;
#(
   parameter int unsigned NUM_FWD  = 3,
   parameter int unsigned STALL_CW = 16
);
   logic                    in_valid;
   logic                    in_ready;
   logic [XLEN-1:0]         in_inst;
   logic [XLEN-1:0]         in_pc;
   logic                    flush;
   logic [4:0]              rf_raddr1;
   logic [4:0]              rf_raddr2;
   logic [XLEN-1:0]         rf_rdata1;
   logic [XLEN-1:0]         rf_rdata2;
   logic [5*NUM_FWD-1:0]    fwd_rd;
   logic [NUM_FWD-1:0]      fwd_pending;
   logic [XLEN*NUM_FWD-1:0] fwd_data;
   logic                    out_valid;
   logic                    out_ready;
   logic [XLEN-1:0]         out_pc;
   logic [XLEN-1:0]         out_rs1v;
   logic [XLEN-1:0]         out_rs2v;
   logic [4:0]              out_rd;
   logic [DCR_W-1:0]        out_dcr;
   logic [XLEN-1:0]         out_imm;
   logic [XLEN-1:0]         out_tgt;
   logic [STALL_CW-1:0]     stall_cnt;

   modport master (
      output in_valid, in_inst, in_pc, flush, rf_rdata1, rf_rdata2,
             fwd_rd, fwd_pending, fwd_data, out_ready,
      input  in_ready, rf_raddr1, rf_raddr2, out_valid, out_pc, out_rs1v, out_rs2v,
             out_rd, out_dcr, out_imm, out_tgt, stall_cnt
   );

   modport slave (
      input  in_valid, in_inst, in_pc, flush, rf_rdata1, rf_rdata2,
             fwd_rd, fwd_pending, fwd_data, out_ready,
      output in_ready, rf_raddr1, rf_raddr2, out_valid, out_pc, out_rs1v, out_rs2v,
             out_rd, out_dcr, out_imm, out_tgt, stall_cnt
   );
endinterface

// File: rtl/rv32_fwd_mux.sv
// Operand forwarding mux: lowest-index matching source wins, x0 never matches.
module rv32_fwd_mux
   import rv32_pkg::*;
#(
   parameter int unsigned NUM_FWD = 3
) (
   input  logic [4:0]              addr,
   input  logic [XLEN-1:0]         rf_data,
   input  logic [5*NUM_FWD-1:0]    fwd_rd,
   input  logic [NUM_FWD-1:0]      fwd_pending,
   input  logic [XLEN*NUM_FWD-1:0] fwd_data,
   output logic [XLEN-1:0]         value,
   output logic                    hit,
   output logic                    pending_hit
);

   // Scan oldest to youngest so the youngest match overwrites
   always_comb begin
      value       = rf_data;
      hit         = 1'b0;
      pending_hit = 1'b0;
      for (int i = NUM_FWD - 1; i >= 0; i--) begin
         if (addr != 5'd0 && fwd_rd[i*5 +: 5] == addr) begin
            value       = fwd_data[i*XLEN +: XLEN];
            hit         = 1'b1;
            pending_hit = fwd_pending[i];
         end
      end
   end

endmodule

// File: rtl/rv32_decode_fwd.sv
// RV32IM decode stage: type/immediate decode, operand forwarding, load-use interlock,
// registered payload towards EX with valid/ready on both sides.
module rv32_decode_fwd
   import rv32_pkg::*;
#(
   parameter int unsigned NUM_FWD   = 3,
   parameter bit          BYPASS_EN = 1'b1,
   parameter int unsigned STALL_CW  = 16
) (
   input logic               clk,
   input logic               rst,
   rv32_decode_fwd_if.slave  bus
);

   logic [6:0]       opcode;
   logic [2:0]       f3;
   logic [6:0]       f7;
   logic [4:0]       rs1_addr, rs2_addr;
   logic [DCR_W-1:0] dcr_d;
   logic [XLEN-1:0]  imm_d, tgt_base, tgt_sum;
   logic [4:0]       rd_d;
   logic [XLEN-1:0]  rs1_val, rs2_val;
   logic             rs1_hit, rs2_hit, rs1_pend, rs2_pend;
   logic             use_rs1, use_rs2, hazard, in_ready, accept;

   logic             out_valid_q;
   logic [XLEN-1:0]  out_pc_q, out_rs1v_q, out_rs2v_q, out_imm_q, out_tgt_q;
   logic [4:0]       out_rd_q;
   logic [DCR_W-1:0] out_dcr_q;
   logic [STALL_CW-1:0] stall_q;

   assign opcode   = bus.in_inst[6:0];
   assign f3       = bus.in_inst[14:12];
   assign f7       = bus.in_inst[31:25];
   assign rs1_addr = bus.in_inst[19:15];
   assign rs2_addr = bus.in_inst[24:20];
   assign bus.rf_raddr1 = rs1_addr;
   assign bus.rf_raddr2 = rs2_addr;

   // Instruction type, decode word, immediate and destination register
   always_comb begin
      dcr_d = '0;
      imm_d = '0;
      rd_d  = bus.in_inst[11:7];
      case (opcode)
         OP_R: begin
            dcr_d[DCR_R]   = 1'b1;
            dcr_d[DCR_MUL] = (f7 == 7'b0000001);
            dcr_d[DCR_F3_LSB +: 3] = f3;
            if (f7 != 7'b0000001) begin
               dcr_d[DCR_ALUOP_LSB +: 3] = alu_op(f3, f7[5]);
               if (f3[1:0] == 2'b01) begin
                  dcr_d[DCR_SFT] = 1'b1;
                  dcr_d[DCR_SFTOP_LSB +: 2] = {f3[2] & f7[5], f3[2]};
               end
            end
         end
         OP_IMM: begin
            dcr_d[DCR_I_CS] = 1'b1;
            dcr_d[DCR_F3_LSB +: 3] = f3;
            dcr_d[DCR_ALUOP_LSB +: 3] = alu_op(f3, 1'b0);
            if (f3[1:0] == 2'b01) begin
               dcr_d[DCR_SFT] = 1'b1;
               dcr_d[DCR_SFTOP_LSB +: 2] = {f3[2] & f7[5], f3[2]};
            end
            imm_d = {{20{bus.in_inst[31]}}, bus.in_inst[31:20]};
         end
         OP_LOAD: begin
            dcr_d[DCR_I_L] = 1'b1;
            dcr_d[DCR_F3_LSB +: 3] = f3;
            imm_d = {{20{bus.in_inst[31]}}, bus.in_inst[31:20]};
         end
         OP_JALR: begin
            dcr_d[DCR_I_J] = 1'b1;
            dcr_d[DCR_F3_LSB +: 3] = f3;
            imm_d = {{20{bus.in_inst[31]}}, bus.in_inst[31:20]};
         end
         OP_STORE: begin
            dcr_d[DCR_S] = 1'b1;
            dcr_d[DCR_F3_LSB +: 3] = f3;
            imm_d = {{20{bus.in_inst[31]}}, bus.in_inst[31:25], bus.in_inst[11:7]};
            rd_d  = 5'd0;
         end
         OP_AUIPC: begin
            dcr_d[DCR_U]     = 1'b1;
            dcr_d[DCR_AUIPC] = 1'b1;
            imm_d = {bus.in_inst[31:12], 12'b0};
         end
         OP_LUI: begin
            dcr_d[DCR_U] = 1'b1;
            imm_d = {bus.in_inst[31:12], 12'b0};
         end
         OP_BRANCH: begin
            dcr_d[DCR_B] = 1'b1;
            dcr_d[DCR_F3_LSB +: 3] = f3;
            dcr_d[DCR_ALUOP_LSB +: 3] = ALU_SUB;
            imm_d = {{20{bus.in_inst[31]}}, bus.in_inst[7], bus.in_inst[30:25],
                     bus.in_inst[11:8], 1'b0};
            rd_d  = 5'd0;
         end
         OP_JAL: begin
            dcr_d[DCR_J] = 1'b1;
            imm_d = {{12{bus.in_inst[31]}}, bus.in_inst[19:12], bus.in_inst[20],
                     bus.in_inst[30:21], 1'b0};
         end
         default: rd_d = 5'd0;  // illegal opcode flows through as a NOP
      endcase
      dcr_d[DCR_I] = dcr_d[DCR_I_CS] | dcr_d[DCR_I_L] | dcr_d[DCR_I_J];
   end

   rv32_fwd_mux #(.NUM_FWD(NUM_FWD)) u_fwd_rs1 (
      .addr        (rs1_addr),
      .rf_data     (bus.rf_rdata1),
      .fwd_rd      (bus.fwd_rd),
      .fwd_pending (bus.fwd_pending),
      .fwd_data    (bus.fwd_data),
      .value       (rs1_val),
      .hit         (rs1_hit),
      .pending_hit (rs1_pend)
   );

   rv32_fwd_mux #(.NUM_FWD(NUM_FWD)) u_fwd_rs2 (
      .addr        (rs2_addr),
      .rf_data     (bus.rf_rdata2),
      .fwd_rd      (bus.fwd_rd),
      .fwd_pending (bus.fwd_pending),
      .fwd_data    (bus.fwd_data),
      .value       (rs2_val),
      .hit         (rs2_hit),
      .pending_hit (rs2_pend)
   );

   assign use_rs1 = dcr_d[DCR_R] | dcr_d[DCR_I] | dcr_d[DCR_S] | dcr_d[DCR_B];
   assign use_rs2 = dcr_d[DCR_R] | dcr_d[DCR_S] | dcr_d[DCR_B];
   assign hazard  = (use_rs1 & (BYPASS_EN ? rs1_pend : rs1_hit)) |
                    (use_rs2 & (BYPASS_EN ? rs2_pend : rs2_hit));

   assign in_ready     = ~hazard & (~out_valid_q | bus.out_ready);
   assign accept       = bus.in_valid & in_ready & ~bus.flush;
   assign bus.in_ready = in_ready;

   assign tgt_base = dcr_d[DCR_I_J] ? rs1_val : bus.in_pc;
   assign tgt_sum  = tgt_base + imm_d;

   // Valid flag and reset-cleared payload fields; flush beats accept
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_rd_q    <= 5'd0;
         out_dcr_q   <= '0;
      end else if (bus.flush) begin
         out_valid_q <= 1'b0;
      end else if (accept) begin
         out_valid_q <= 1'b1;
         out_rd_q    <= rd_d;
         out_dcr_q   <= dcr_d;
      end else if (bus.out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   // Data payload fields, loaded only on accept
   always_ff @(posedge clk) begin
      if (!rst && accept) begin
         out_pc_q   <= bus.in_pc;
         out_rs1v_q <= rs1_val;
         out_rs2v_q <= rs2_val;
         out_imm_q  <= imm_d;
         out_tgt_q  <= tgt_sum & ~32'h3;
      end
   end

   // Saturating count of cycles an offered instruction is held back by a hazard
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q <= '0;
      end else if (bus.in_valid && hazard && !bus.flush && stall_q != '1) begin
         stall_q <= stall_q + 1'b1;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_pc    = out_pc_q;
   assign bus.out_rs1v  = out_rs1v_q;
   assign bus.out_rs2v  = out_rs2v_q;
   assign bus.out_rd    = out_rd_q;
   assign bus.out_dcr   = out_dcr_q;
   assign bus.out_imm   = out_imm_q;
   assign bus.out_tgt   = out_tgt_q;
   assign bus.stall_cnt = stall_q;

endmodule

// File: tb/tb_rv32_decode_fwd.sv
// Scoreboard bench for rv32_decode_fwd: expected payloads are queued when the bench sees
// its instruction accepted and compared when EX takes the payload.
module tb_rv32_decode_fwd;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] rs1v;
      logic [31:0] rs2v;
      logic [31:0] rd;
      logic [31:0] dcr;
      logic [31:0] imm;
      logic [31:0] tgt;
   } exp_t;

   logic clk;
   logic rst;
   int   n_vec = 0;
   int   n_err = 0;
   exp_t sb[$];
   exp_t exp_cur;
   logic accepted;
   logic rdy_seen;

   rv32_decode_fwd_if #(.NUM_FWD(3), .STALL_CW(16)) bus ();

   rv32_decode_fwd #(.NUM_FWD(3), .BYPASS_EN(1'b1), .STALL_CW(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Stand-in regfile: x0 reads 0, xN reads 0x10000 + N
   assign bus.rf_rdata1 = (bus.rf_raddr1 == 5'd0) ? 32'h0 : {27'h800, bus.rf_raddr1};
   assign bus.rf_rdata2 = (bus.rf_raddr2 == 5'd0) ? 32'h0 : {27'h800, bus.rf_raddr2};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] want);
      n_vec++;
      if (obs !== want) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, want);
      end
   endtask

   function automatic exp_t mk(input logic [31:0] pc, rs1v, rs2v, rd, dcr, imm, tgt);
      exp_t e;
      e.pc = pc; e.rs1v = rs1v; e.rs2v = rs2v; e.rd = rd;
      e.dcr = dcr; e.imm = imm; e.tgt = tgt;
      return e;
   endfunction

   task automatic cmp_out(input exp_t e);
      check_eq("out_pc",   bus.out_pc,           e.pc);
      check_eq("out_rs1v", bus.out_rs1v,         e.rs1v);
      check_eq("out_rs2v", bus.out_rs2v,         e.rs2v);
      check_eq("out_rd",   {27'b0, bus.out_rd},  e.rd);
      check_eq("out_dcr",  {12'b0, bus.out_dcr}, e.dcr);
      check_eq("out_imm",  bus.out_imm,          e.imm);
      check_eq("out_tgt",  bus.out_tgt,          e.tgt);
   endtask

   // One clock: observe at negedge (scoreboard pop/push), return 1 time unit after posedge
   task automatic tick();
      exp_t e;
      @(negedge clk);
      rdy_seen = bus.in_ready;
      if (bus.out_valid && bus.out_ready) begin
         if (sb.size() == 0) begin
            check_eq("spurious_out", {31'b0, bus.out_valid}, 32'd0);
         end else begin
            e = sb.pop_front();
            cmp_out(e);
         end
      end
      if (bus.flush) sb.delete();
      accepted = bus.in_valid & bus.in_ready & ~bus.flush;
      if (accepted) sb.push_back(exp_cur);
      @(posedge clk);
      #1;
   endtask

   task automatic set_fwd(input int i, input logic [4:0] rd, input logic pend,
                          input logic [31:0] data);
      bus.fwd_rd[i*5 +: 5]    = rd;
      bus.fwd_pending[i]      = pend;
      bus.fwd_data[i*32 +: 32] = data;
   endtask

   task automatic clr_fwd();
      bus.fwd_rd      = '0;
      bus.fwd_pending = '0;
      bus.fwd_data    = '0;
   endtask

   // Offer one instruction until accepted (bounded), then withdraw it
   task automatic send(input logic [31:0] inst, input logic [31:0] pc, input exp_t e);
      exp_cur      = e;
      bus.in_inst  = inst;
      bus.in_pc    = pc;
      bus.in_valid = 1'b1;
      for (int n = 0; n < 8; n++) begin
         tick();
         if (accepted) break;
      end
      check_eq("accept", {31'b0, accepted}, 32'd1);
      bus.in_valid = 1'b0;
   endtask

   initial begin
      rst           = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_inst   = 32'h0070_0293;
      bus.in_pc     = 32'h100;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b1;
      accepted      = 1'b0;
      rdy_seen      = 1'b0;
      clr_fwd();

      // Reset held two cycles with an instruction offered
      repeat (2) begin
         @(posedge clk);
         #1;
         check_eq("rst_valid", {31'b0, bus.out_valid}, 32'd0);
         check_eq("rst_rd",    {27'b0, bus.out_rd},    32'd0);
         check_eq("rst_dcr",   {12'b0, bus.out_dcr},   32'd0);
         check_eq("rst_stall", {16'b0, bus.stall_cnt}, 32'd0);
      end
      rst          = 1'b0;
      bus.in_valid = 1'b0;
      check_eq("rst_raddr1", {27'b0, bus.rf_raddr1}, 32'd0);
      check_eq("rst_raddr2", {27'b0, bus.rf_raddr2}, 32'd7);

      // addi x5,x0,7; x0 must ignore a source claiming rd=0
      set_fwd(0, 5'd0, 1'b0, 32'hDEAD);
      send(32'h0070_0293, 32'h100,
           mk(32'h100, 32'h0, 32'h10007, 32'd5, 32'h4040, 32'd7, 32'h104));
      tick();
      clr_fwd();

      // add x3,x1,x2 with priority between forwarding sources
      set_fwd(0, 5'd1, 1'b0, 32'hAA);
      set_fwd(1, 5'd2, 1'b0, 32'hCC);
      set_fwd(2, 5'd1, 1'b0, 32'hBB);
      send(32'h0020_81B3, 32'h104,
           mk(32'h104, 32'hAA, 32'hCC, 32'd3, 32'h8000, 32'd0, 32'h104));
      tick();
      clr_fwd();

      // sub x4,x1,x2 from the regfile, back-to-back with sw x2,12(x1)
      send(32'h4020_8233, 32'h108,
           mk(32'h108, 32'h10001, 32'h10002, 32'd4, 32'h8004, 32'd0, 32'h108));
      send(32'h0020_A623, 32'h10C,
           mk(32'h10C, 32'h10001, 32'h10002, 32'd0, 32'h20800, 32'd12, 32'h118));
      tick();

      // Load-use: rs1 (x1) pending on source 0 for one cycle
      set_fwd(0, 5'd1, 1'b1, 32'h55);
      exp_cur      = mk(32'h120, 32'h55, 32'h55, 32'd7, 32'h4040, 32'd1, 32'h120);
      bus.in_inst  = 32'h0010_8393;
      bus.in_pc    = 32'h120;
      bus.in_valid = 1'b1;
      tick();
      check_eq("stall_acc",   {31'b0, accepted},       32'd0);
      check_eq("stall_rdy",   {31'b0, rdy_seen},       32'd0);
      check_eq("stall_valid", {31'b0, bus.out_valid},  32'd0);
      check_eq("stall_cnt1",  {16'b0, bus.stall_cnt},  32'd1);
      set_fwd(0, 5'd1, 1'b0, 32'h55);
      tick();
      check_eq("unstall_acc", {31'b0, accepted},       32'd1);
      bus.in_valid = 1'b0;
      tick();
      clr_fwd();
      check_eq("stall_cnt2",  {16'b0, bus.stall_cnt},  32'd1);

      // jalr x1,8(x6) with x6 forwarded; jal x1,-4 ignores a pending rs1 field match
      set_fwd(1, 5'd6, 1'b0, 32'h2003);
      send(32'h0083_00E7, 32'h200,
           mk(32'h200, 32'h2003, 32'h10008, 32'd1, 32'h1040, 32'd8, 32'h2008));
      tick();
      clr_fwd();
      set_fwd(0, 5'd31, 1'b1, 32'h77);
      send(32'hFFDF_F0EF, 32'h40,
           mk(32'h40, 32'h77, 32'h1001D, 32'd1, 32'h100, 32'hFFFF_FFFC, 32'h3C));
      tick();
      clr_fwd();

      // Illegal opcode passes as a NOP
      send(32'hFFFF_FFFF, 32'h404,
           mk(32'h404, 32'h1001F, 32'h1001F, 32'd0, 32'h0, 32'h0, 32'h404));
      tick();

      // EX back-pressure, then a flush drops both the held payload and the offered input
      bus.out_ready = 1'b0;
      send(32'hFFF0_0493, 32'h300,
           mk(32'h300, 32'h0, 32'h1001F, 32'd9, 32'h4040, 32'hFFFF_FFFF, 32'h2FC));
      exp_cur      = mk(32'h304, 32'h0, 32'h10003, 32'd10, 32'h4040, 32'd3, 32'h304);
      bus.in_inst  = 32'h0030_0513;
      bus.in_pc    = 32'h304;
      bus.in_valid = 1'b1;
      tick();
      check_eq("hold_rdy", {31'b0, rdy_seen}, 32'd0);
      cmp_out(mk(32'h300, 32'h0, 32'h1001F, 32'd9, 32'h4040, 32'hFFFF_FFFF, 32'h2FC));
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      check_eq("flush_rdy",   {31'b0, rdy_seen},      32'd0);
      check_eq("flush_acc",   {31'b0, accepted},      32'd0);
      check_eq("flush_valid", {31'b0, bus.out_valid}, 32'd0);
      bus.in_valid = 1'b0;
      tick();
      check_eq("post_flush_valid", {31'b0, bus.out_valid}, 32'd0);
      bus.out_ready = 1'b1;
      repeat (2) tick();
      check_eq("final_stall", {16'b0, bus.stall_cnt}, 32'd1);
      check_eq("sb_left", sb.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
